fire4_squeeze_ofm_writer: RTL and testbench

- Downstream consumer of the fire4 squeeze layer.
- Captures each DSP_NO-wide output-pixel vector on the layer's sample pulse and serialises it into a channel-major feature-map RAM, one word per clock, for the fire4 expand layers.
- Counts written pixels and raises a one-cycle ram_feedback pulse when the full WOUT x WOUT map is stored.
- Flags overrun if the squeeze layer samples again while a write burst is still in progress.

---
 rtl/fire4_pkg.sv | 16 +
 rtl/fire4_squeeze_ofm_writer.sv | 99 +++++++++
 tb/tb_fire4_squeeze_ofm_writer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fire4_pkg.sv
// Shared constants and write-FSM state type for the fire4 squeeze output writer.
package fire4_pkg;

  localparam int WOUT   = 32;
  localparam int DSP_NO = 32;
  localparam int WIDTH  = 16;
  localparam int PIX_NO = WOUT * WOUT;
  localparam int ADDR_W = $clog2(DSP_NO * PIX_NO);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/fire4_squeeze_ofm_writer.sv
// Serialises each squeeze-layer output pixel vector into a channel-major feature-map RAM,
// one channel word per clock, and signals when the whole map has been stored.
module fire4_squeeze_ofm_writer
  import fire4_pkg::*;
#(
  parameter int WOUT   = fire4_pkg::WOUT,
  parameter int DSP_NO = fire4_pkg::DSP_NO,
  parameter int WIDTH  = fire4_pkg::WIDTH,
  parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fire4_squeeze_sample,
  input  logic [WIDTH-1:0]               ofm_i [0:DSP_NO-1],
  output logic                           wr_en,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [WIDTH-1:0]               wr_data,
  output logic                           busy,
  output logic [$clog2(WOUT*WOUT):0]     pixel_count,
  output logic                           ram_feedback,
  output logic                           layer_done,
  output logic                           overflow
);

  localparam int PIX_NO = WOUT * WOUT;
  localparam int CH_W   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PC_W   = $clog2(PIX_NO) + 1;

  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(DSP_NO - 1);
  localparam logic [PC_W-1:0]   LAST_PIX  = PC_W'(PIX_NO - 1);
  localparam logic [ADDR_W-1:0] CH_STRIDE = ADDR_W'(PIX_NO);

  wr_state_t        state;
  logic [CH_W-1:0]  ch;
  logic [WIDTH-1:0] cap_p0 [0:DSP_NO-1];

  logic             last_ch;
  logic             map_full;
  logic             accept;
  logic             overrun;
  logic [PC_W-1:0]  pix_nxt;
  logic [CH_W-1:0]  ch_nxt;

  // ch is the channel currently presented on the write port
  always_comb begin
    last_ch  = (state == WRITE) && (ch == LAST_CH);
    map_full = last_ch && (pixel_count == LAST_PIX);
    accept   = fire4_squeeze_sample && !map_full && ((state == IDLE) || last_ch);
    overrun  = fire4_squeeze_sample && (state == WRITE) && !last_ch;
    pix_nxt  = pixel_count + PC_W'(last_ch);
    ch_nxt   = ch + CH_W'(1);
  end

  // Capture / write stage: address advances by one channel stride per word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ch           <= '0;
      pixel_count  <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      ram_feedback <= 1'b0;
      layer_done   <= 1'b0;
      overflow     <= 1'b0;
      for (int i = 0; i < DSP_NO; i++) cap_p0[i] <= '0;
    end else begin
      ram_feedback <= 1'b0;
      if (overrun) overflow <= 1'b1;
      if (last_ch) pixel_count <= pix_nxt;

      if (map_full) begin
        state        <= DONE;
        wr_en        <= 1'b0;
        ram_feedback <= 1'b1;
        layer_done   <= 1'b1;
      end else if (accept) begin
        state   <= WRITE;
        ch      <= '0;
        cap_p0  <= ofm_i;
        wr_en   <= 1'b1;
        wr_addr <= ADDR_W'(pix_nxt);
        wr_data <= ofm_i[0];
      end else if (state == WRITE) begin
        if (last_ch) begin
          state <= IDLE;
          wr_en <= 1'b0;
        end else begin
          ch      <= ch_nxt;
          wr_addr <= wr_addr + CH_STRIDE;
          wr_data <= cap_p0[ch_nxt];
        end
      end
    end
  end

  assign busy = (state == WRITE);

endmodule

// File: tb/tb_fire4_squeeze_ofm_writer.sv
// Directed-sequence bench for fire4_squeeze_ofm_writer with randomized pixel data and a
// transaction-level reference model of expected RAM writes.
module tb_fire4_squeeze_ofm_writer;

  localparam int WOUT   = 4;
  localparam int DSP_NO = 32;
  localparam int WIDTH  = 16;
  localparam int PIX    = WOUT * WOUT;
  localparam int ADDR_W = $clog2(DSP_NO * PIX);
  localparam int PC_W   = $clog2(PIX) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample = 1'b0;
  logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              busy;
  logic [PC_W-1:0]   pixel_count;
  logic              ram_feedback;
  logic              layer_done;
  logic              overflow;

  always #5 clk = ~clk;

  fire4_squeeze_ofm_writer #(
    .WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fire4_squeeze_sample(sample),
    .ofm_i(ofm),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .pixel_count(pixel_count),
    .ram_feedback(ram_feedback),
    .layer_done(layer_done),
    .overflow(overflow)
  );

  typedef struct packed {
    logic [31:0]       cyc;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t act_q[$];
  int  exp_rf[$];
  int  act_rf[$];

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  // reference model state: time of last accepted sample, pixels accepted, completion edge
  int last_acc;
  int pix_m;
  int done_edge;
  bit ovf_m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) act_q.push_back('{cyc: cyc, addr: wr_addr, data: wr_data});
    if (ram_feedback === 1'b1) act_rf.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    last_acc  = -100000;
    pix_m     = 0;
    done_edge = 1 << 30;
    ovf_m     = 1'b0;
  endtask

  // A sample at edge T is accepted if the map is not finished and the previous burst
  // has reached its last channel; otherwise it is an overrun.
  task automatic model_sample(input int t);
    if (t >= done_edge) return;
    if (t >= last_acc + DSP_NO) begin
      for (int c = 0; c < DSP_NO; c++)
        exp_q.push_back('{cyc: 32'(t + c), addr: ADDR_W'(c * PIX + pix_m), data: ofm[c]});
      last_acc = t;
      pix_m++;
      if (pix_m == PIX) begin
        done_edge = t + DSP_NO;
        exp_rf.push_back(t + DSP_NO);
      end
    end else begin
      ovf_m = 1'b1;
    end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < DSP_NO; c++) ofm[c] = WIDTH'($urandom);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_at(input int t);
    wait_until(t - 1);
    sample = 1'b1;
    model_sample(cyc + 1);
    @(posedge clk);
    #1;
    sample = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, 64'(act_q.size()), 64'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_wr%0d", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
    check({tag, "_nfeedback"}, 64'(act_rf.size()), 64'(exp_rf.size()));
    n = (act_rf.size() < exp_rf.size()) ? act_rf.size() : exp_rf.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_feedback%0d", tag, i), 64'(act_rf[i]), 64'(exp_rf[i]));
    exp_q.delete();
    act_q.delete();
    exp_rf.delete();
    act_rf.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pixel_count"}, 64'(pixel_count), 64'd0);
    check({tag, "_ram_feedback"}, 64'(ram_feedback), 64'd0);
    check({tag, "_layer_done"}, 64'(layer_done), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  task automatic do_reset();
    sample = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    act_q.delete();
    exp_rf.delete();
    act_rf.delete();
  endtask

  initial begin
    int t0;
    int t1;
    for (int c = 0; c < DSP_NO; c++) ofm[c] = '0;
    model_reset();

    // reset state
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // single sample with a ramp pattern
    for (int c = 0; c < DSP_NO; c++) ofm[c] = WIDTH'(16'h0100 + c);
    t0 = cyc + 2;
    pulse_at(t0);
    wait_until(t0 + DSP_NO + 4);
    check_writes("single");
    check("single_pixel_count", 64'(pixel_count), 64'd1);
    check("single_busy", 64'(busy), 64'd0);
    check("single_overflow", 64'(overflow), 64'd0);

    // back-to-back samples: no gap between bursts
    do_reset();
    fill_rand();
    t0 = cyc + 3;
    pulse_at(t0);
    fill_rand();
    pulse_at(t0 + DSP_NO);
    wait_until(t0 + 2 * DSP_NO + 4);
    check_writes("b2b");
    check("b2b_pixel_count", 64'(pixel_count), 64'(pix_m));
    check("b2b_overflow", 64'(overflow), 64'd0);

    // overrun: second sample mid-burst is dropped
    do_reset();
    fill_rand();
    t0 = cyc + 2;
    pulse_at(t0);
    fill_rand();
    pulse_at(t0 + 10);
    wait_until(t0 + 2 * DSP_NO + 4);
    check_writes("overrun");
    check("overrun_overflow", 64'(overflow), 64'(ovf_m));
    check("overrun_pixel_count", 64'(pixel_count), 64'd1);

    // full layer with random spacing, then extra strobes including one on the completion edge
    do_reset();
    t1 = cyc + 2;
    for (int k = 0; k < PIX; k++) begin
      fill_rand();
      pulse_at(t1);
      if (k < PIX - 1) t1 = t1 + DSP_NO + int'($urandom_range(0, 20));
    end
    fill_rand();
    pulse_at(t1 + DSP_NO);
    fill_rand();
    pulse_at(t1 + DSP_NO + 5);
    fill_rand();
    pulse_at(t1 + DSP_NO + 40);
    wait_until(t1 + DSP_NO + 50);
    check_writes("layer");
    check("layer_done", 64'(layer_done), 64'd1);
    check("layer_pixel_count", 64'(pixel_count), 64'(PIX));
    check("layer_overflow", 64'(overflow), 64'd0);
    check("layer_busy", 64'(busy), 64'd0);
    check("layer_wr_en", 64'(wr_en), 64'd0);

    // reset asserted at channel 12 of the second pixel's burst
    do_reset();
    fill_rand();
    t0 = cyc + 2;
    pulse_at(t0);
    fill_rand();
    t1 = t0 + DSP_NO;
    pulse_at(t1);
    wait_until(t1 + 12);
    check("midrst_wr_en_before", 64'(wr_en), 64'd1);
    check("midrst_addr_before", 64'(wr_addr), 64'(12 * PIX + 1));
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    while (exp_q.size() > 0 && int'(exp_q[exp_q.size() - 1].cyc) >= t1 + 12) void'(exp_q.pop_back());
    check_writes("midrst");
    // strobe while reset is held is ignored
    @(posedge clk);
    #1;
    fill_rand();
    sample = 1'b1;
    @(posedge clk);
    #1;
    sample = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    fill_rand();
    t0 = cyc + 2;
    pulse_at(t0);
    wait_until(t0 + DSP_NO + 4);
    check_writes("after_rst");
    check("after_rst_pixel_count", 64'(pixel_count), 64'd1);
    check("after_rst_overflow", 64'(overflow), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
